// File: rtl/fl_mark_pkg.sv
// rtl/fl_mark_pkg.sv - shared types and sizing helpers for the FrameLink mark extractor
package fl_mark_pkg;

  typedef enum logic [1:0] {
    ST_PRE,
    ST_MARK,
    ST_PASS
  } t_fl_state;

  function automatic int words(input int bytes, input int dw);
    return bytes / (dw / 8);
  endfunction

  function automatic int FL_REM_W(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction

endpackage

// File: rtl/fl_mark_extract_if.sv
// rtl/fl_mark_extract_if.sv - FrameLink stream bundle with source (master) and sink (slave) views
interface fl_mark_extract_if import fl_mark_pkg::*; #(
  parameter int DATA_WIDTH = 32
);
  localparam int REM_W = FL_REM_W(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] DATA;
  logic [REM_W-1:0]      REM;
  logic                  SOF_N;
  logic                  EOF_N;
  logic                  SOP_N;
  logic                  EOP_N;
  logic                  SRC_RDY_N;
  logic                  DST_RDY_N;

  modport master (output DATA, REM, SOF_N, EOF_N, SOP_N, EOP_N, SRC_RDY_N, input DST_RDY_N);
  modport slave  (input DATA, REM, SOF_N, EOF_N, SOP_N, EOP_N, SRC_RDY_N, output DST_RDY_N);

endinterface

// File: rtl/fl_mark_shreg.sv
// rtl/fl_mark_shreg.sv - mark shift register; words enter at the top so the first word ends in the LSBs
module fl_mark_shreg #(
  parameter int DATA_WIDTH = 32,
  parameter int MARK_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  last_i,
  input  logic                  next_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [MARK_W-1:0]     mark_o,
  output logic                  vld_o
);

  logic [MARK_W-1:0] mark_q, mark_d, shifted;
  logic              vld_q, vld_d;

  generate
    if (MARK_W > DATA_WIDTH) begin : g_shift
      assign shifted = {data_i, mark_q[MARK_W-1:DATA_WIDTH]};
    end else begin : g_single
      assign shifted = data_i;
    end
  endgenerate

  // Completing a new mark wins over the clear of the one being handed off.
  always_comb begin
    mark_d = load_i ? shifted : mark_q;
    vld_d  = vld_q;
    if (last_i) begin
      vld_d = 1'b1;
    end else if (next_i && vld_q) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mark_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      mark_q <= mark_d;
      vld_q  <= vld_d;
    end
  end

  assign mark_o = mark_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/fl_mark_extract.sv
// rtl/fl_mark_extract.sv - strips a fixed mark from the first FrameLink part and presents it on MARK.
// Define FL_MARK_EXTRACT_KEEP_EN to capture the mark while still forwarding it on TX.
module fl_mark_extract import fl_mark_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int OFFSET     = 0,
  parameter int MARK_SIZE  = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  fl_mark_extract_if.slave       RX,
  fl_mark_extract_if.master      TX,
  output logic [MARK_SIZE*8-1:0] MARK,
  output logic                   MARK_VLD,
  input  logic                   MARK_NEXT,
  output logic                   MARK_ERR
);

  localparam int W     = words(OFFSET, DATA_WIDTH);
  localparam int N     = words(MARK_SIZE, DATA_WIDTH);
  localparam int CNT_W = $clog2(W + N + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((W == 0) ? 0 : W - 1);
  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(W + N - 1);
  localparam t_fl_state ST_START = (W == 0) ? ST_MARK : ST_PRE;

  t_fl_state        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rx_dst_rdy_n, rx_xfer, absorb, stall;
  logic             mark_load, mark_last;

  // A mark word that ends the part is not mark data; it travels on like a pass word.
  assign absorb       = (state_q == ST_MARK) & RX.EOP_N;
  assign stall        = MARK_VLD & ~MARK_NEXT;
  assign rx_xfer      = ~RX.SRC_RDY_N & ~rx_dst_rdy_n;
  assign RX.DST_RDY_N = rx_dst_rdy_n;

  assign TX.DATA  = RX.DATA;
  assign TX.REM   = RX.REM;
  assign TX.EOF_N = RX.EOF_N;
  assign TX.EOP_N = RX.EOP_N;

`ifdef FL_MARK_EXTRACT_KEEP_EN
  assign rx_dst_rdy_n = TX.DST_RDY_N | (absorb & stall);
  assign TX.SRC_RDY_N = RESET | RX.SRC_RDY_N | (absorb & stall);
  assign TX.SOF_N     = RX.SOF_N;
  assign TX.SOP_N     = RX.SOP_N;
`else
  logic sof_pend_q, sof_pend_d, sop_pend_q, sop_pend_d, tx_xfer;

  assign rx_dst_rdy_n = absorb ? stall : TX.DST_RDY_N;
  assign TX.SRC_RDY_N = RESET | absorb | RX.SRC_RDY_N;
  assign TX.SOF_N     = RX.SOF_N & ~sof_pend_q;
  assign TX.SOP_N     = RX.SOP_N & ~sop_pend_q;
  assign tx_xfer      = ~TX.SRC_RDY_N & ~TX.DST_RDY_N;

  // With the mark at the very start, the delimiters of the dropped words move to the next sent word.
  always_comb begin
    sof_pend_d = sof_pend_q & ~tx_xfer;
    sop_pend_d = sop_pend_q & ~tx_xfer;
    if ((W == 0) && rx_xfer && absorb) begin
      if (!RX.SOF_N) sof_pend_d = 1'b1;
      if (!RX.SOP_N) sop_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sof_pend_q <= 1'b0;
      sop_pend_q <= 1'b0;
    end else begin
      sof_pend_q <= sof_pend_d;
      sop_pend_q <= sop_pend_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    mark_load = 1'b0;
    mark_last = 1'b0;
    if (rx_xfer) begin
      if (state_q != ST_PASS) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_PRE: begin
          if (!RX.EOF_N)               state_d = ST_START;
          else if (!RX.EOP_N)          state_d = ST_PASS;
          else if (cnt_q == PRE_LAST)  state_d = ST_MARK;
        end
        ST_MARK: begin
          if (!RX.EOP_N) begin
            err_d   = 1'b1;
            state_d = !RX.EOF_N ? ST_START : ST_PASS;
          end else begin
            mark_load = 1'b1;
            if (cnt_q == MARK_LAST) begin
              mark_last = 1'b1;
              state_d   = ST_PASS;
            end
          end
        end
        ST_PASS: begin
          if (!RX.EOF_N) state_d = ST_START;
        end
        default: state_d = ST_START;
      endcase
      if (!RX.EOF_N) cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_START;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign MARK_ERR = err_q;

  fl_mark_shreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MARK_W     (MARK_SIZE * 8)
  ) u_shreg (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (mark_load),
    .last_i (mark_last),
    .next_i (MARK_NEXT),
    .data_i (RX.DATA),
    .mark_o (MARK),
    .vld_o  (MARK_VLD)
  );

endmodule

// File: tb/tb_fl_mark_extract.sv
// tb/tb_fl_mark_extract.sv - scoreboard bench: OFFSET=4 and OFFSET=0 extractors, 32-bit data, 8-byte mark
module tb_fl_mark_extract;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fl_mark_extract_if #(.DATA_WIDTH(32)) rx4(), tx4(), rx0(), tx0();

  logic [63:0] mark4, mark0;
  logic        mvld4, mvld0, merr4, merr0;
  logic        mark_next = 1'b1;
  logic        tx_dst_n  = 1'b0;
  logic        sel       = 1'b1;
  logic        rnd_en    = 1'b0;
  logic [31:0] s_data    = '0;
  logic [1:0]  s_rem     = '0;
  logic        s_sof_n = 1'b1, s_eof_n = 1'b1, s_sop_n = 1'b1, s_eop_n = 1'b1, s_src_n = 1'b1;

  assign rx4.DATA = s_data;   assign rx0.DATA = s_data;
  assign rx4.REM = s_rem;     assign rx0.REM = s_rem;
  assign rx4.SOF_N = s_sof_n; assign rx0.SOF_N = s_sof_n;
  assign rx4.EOF_N = s_eof_n; assign rx0.EOF_N = s_eof_n;
  assign rx4.SOP_N = s_sop_n; assign rx0.SOP_N = s_sop_n;
  assign rx4.EOP_N = s_eop_n; assign rx0.EOP_N = s_eop_n;
  assign rx4.SRC_RDY_N = s_src_n | ~sel;
  assign rx0.SRC_RDY_N = s_src_n | sel;
  assign tx4.DST_RDY_N = tx_dst_n;
  assign tx0.DST_RDY_N = tx_dst_n;

  fl_mark_extract #(.DATA_WIDTH(32), .OFFSET(4), .MARK_SIZE(8)) dut4 (
    .CLK(clk), .RESET(rst), .RX(rx4), .TX(tx4),
    .MARK(mark4), .MARK_VLD(mvld4), .MARK_NEXT(mark_next), .MARK_ERR(merr4)
  );

  fl_mark_extract #(.DATA_WIDTH(32), .OFFSET(0), .MARK_SIZE(8)) dut0 (
    .CLK(clk), .RESET(rst), .RX(rx0), .TX(tx0),
    .MARK(mark0), .MARK_VLD(mvld0), .MARK_NEXT(mark_next), .MARK_ERR(merr0)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [1:0]  rem;
    logic        sof_n, eof_n, sop_n, eop_n;
  } txw_t;

  txw_t        q_tx[$];
  logic [63:0] q_mk4[$], q_mk0[$];
  logic [31:0] fw[16];
  logic [1:0]  fr[16];
  int errors = 0, checks = 0;
  int err_exp = 0, err_seen = 0, vld4_cyc = 0, stall4 = 0, tx_pop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %b expected 1", tag, cond);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Spec model: words before the mark and after it are forwarded; a part ending inside the
  // mark forwards its last word and raises an error; OFFSET=0 moves SOF/SOP onto the first sent word.
  task automatic push_exp(input bit d, input int len);
    int   wd;
    bit   first;
    txw_t t;
    wd    = d ? 1 : 0;
    first = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i < wd || i >= wd + 2 || i == len - 1) begin
        t.id    = d;
        t.data  = fw[i];
        t.rem   = fr[i];
        t.sof_n = (i != 0);
        t.sop_n = (i != 0);
        t.eof_n = (i != len - 1);
        t.eop_n = (i != len - 1);
        if (wd == 0 && first) begin
          t.sof_n = 1'b0;
          t.sop_n = 1'b0;
        end
        first = 1'b0;
        q_tx.push_back(t);
      end
    end
    if (len - 1 >= wd + 2) begin
      if (d) q_mk4.push_back({fw[wd+1], fw[wd]});
      else   q_mk0.push_back({fw[wd+1], fw[wd]});
    end else if (len - 1 >= wd) begin
      err_exp++;
    end
  endtask

  task automatic send(input bit d, input int len, input bit partial);
    bit acc;
    if (!partial) push_exp(d, len);
    sel = d;
    for (int i = 0; i < len; i++) begin
      s_data  = fw[i];
      s_rem   = fr[i];
      s_sof_n = (i != 0);
      s_sop_n = (i != 0);
      s_eop_n = partial ? 1'b1 : (i != len - 1);
      s_eof_n = partial ? 1'b1 : (i != len - 1);
      s_src_n = 1'b0;
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = d ? !rx4.DST_RDY_N : !rx0.DST_RDY_N;
        @(posedge clk);
        #1;
      end
      chk_true("rx_accept_in_time", acc);
    end
    s_src_n = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && (q_tx.size() != 0 || q_mk4.size() != 0 || q_mk0.size() != 0); t++)
      tick(1);
    tick(2);
    chk("tx_queue_left", 64'(q_tx.size()), 64'd0);
    chk("mark_queue_left", 64'(q_mk4.size() + q_mk0.size()), 64'd0);
  endtask

  task automatic mon_tx(input txw_t got);
    txw_t e;
    chk_true("tx_word_expected", q_tx.size() != 0);
    if (q_tx.size() != 0) begin
      e = q_tx.pop_front();
      chk("tx_word", 64'(got), 64'(e));
      tx_pop++;
    end
  endtask

  task automatic mon_mk(input bit d, input logic [63:0] got);
    logic [63:0] e;
    if (d) begin
      chk_true("mark4_expected", q_mk4.size() != 0);
      if (q_mk4.size() != 0) begin
        e = q_mk4.pop_front();
        chk("mark4_value", got, e);
      end
    end else begin
      chk_true("mark0_expected", q_mk0.size() != 0);
      if (q_mk0.size() != 0) begin
        e = q_mk0.pop_front();
        chk("mark0_value", got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!tx4.SRC_RDY_N && !tx4.DST_RDY_N)
        mon_tx({1'b1, tx4.DATA, tx4.REM, tx4.SOF_N, tx4.EOF_N, tx4.SOP_N, tx4.EOP_N});
      if (!tx0.SRC_RDY_N && !tx0.DST_RDY_N)
        mon_tx({1'b0, tx0.DATA, tx0.REM, tx0.SOF_N, tx0.EOF_N, tx0.SOP_N, tx0.EOP_N});
      if (mvld4 && mark_next) mon_mk(1'b1, mark4);
      if (mvld0 && mark_next) mon_mk(1'b0, mark0);
      if (mvld4) vld4_cyc++;
      if (merr4) err_seen++;
      if (merr0) err_seen++;
      if (sel && !s_src_n && rx4.DST_RDY_N) stall4++;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      tx_dst_n  = 1'($urandom_range(0, 1));
      mark_next = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t exceeded limit 900000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, e0;
    bit got;
    tick(3);
    tx_dst_n = 1'b1;
    #1;
    chk("rst_rx_dst_follows_1", 64'(rx4.DST_RDY_N), 64'd1);
    tx_dst_n = 1'b0;
    #1;
    chk("rst_rx_dst_follows_0", 64'(rx4.DST_RDY_N), 64'd0);
    chk("rst_tx_src", 64'({tx4.SRC_RDY_N, tx0.SRC_RDY_N}), 64'b11);
    chk("rst_mark_vld", 64'({mvld4, mvld0}), 64'd0);
    chk("rst_mark_err", 64'({merr4, merr0}), 64'd0);
    chk("rst_mark4", mark4, 64'd0);
    rst = 1'b0;
    tick(1);

    // 1: A..E through OFFSET=4 -> A,D,E forwarded, mark {C,B}, valid one cycle
    fw[0] = 32'hA0A0A0A0; fw[1] = 32'hB1B1B1B1; fw[2] = 32'hC2C2C2C2;
    fw[3] = 32'hD3D3D3D3; fw[4] = 32'hE4E4E4E4;
    for (int i = 0; i < 5; i++) fr[i] = 2'd3;
    c0 = tx_pop; vld4_cyc = 0;
    send(1'b1, 5, 1'b0);
    drain();
    chk("t1_tx_words", 64'(tx_pop - c0), 64'd3);
    chk("t1_vld_cycles", 64'(vld4_cyc), 64'd1);

    // 2: B,C,D through OFFSET=0 -> only D, carrying SOF/SOP
    fw[0] = 32'hB1B1B1B1; fw[1] = 32'hC2C2C2C2; fw[2] = 32'hD3D3D3D3;
    c0 = tx_pop;
    send(1'b0, 3, 1'b0);
    drain();
    chk("t2_tx_words", 64'(tx_pop - c0), 64'd1);

    // 3: back-to-back frames with the first mark held unread for 20 cycles
    mark_next = 1'b0; stall4 = 0;
    for (int i = 0; i < 10; i++) begin fw[i] = 32'h3000_0000 + 32'(i); fr[i] = 2'(i); end
    fork
      begin
        send(1'b1, 5, 1'b0);
        for (int i = 0; i < 5; i++) begin fw[i] = fw[i+5]; fr[i] = fr[i+5]; end
        send(1'b1, 5, 1'b0);
      end
      begin
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin @(negedge clk); got = mvld4; end
        chk_true("t3_first_mark_valid", got);
        repeat (20) @(posedge clk);
        #1;
        mark_next = 1'b1;
      end
    join
    drain();
    chk_true("t3_rx_stalled", stall4 >= 15);

    // 4: part ends on the first mark word -> forwarded, error pulse, no mark
    fw[0] = 32'h4444_0000; fw[1] = 32'h4444_0001; fr[0] = 2'd0; fr[1] = 2'd1;
    c0 = tx_pop; e0 = err_seen; c1 = vld4_cyc;
    send(1'b1, 2, 1'b0);
    drain();
    chk("t4_tx_words", 64'(tx_pop - c0), 64'd2);
    chk("t4_err_pulse", 64'(err_seen - e0), 64'd1);
    chk("t4_vld_stays_low", 64'(vld4_cyc - c1), 64'd0);

    // 5: random frames on both extractors under random backpressure
    rnd_en = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin fw[i] = $urandom; fr[i] = 2'($urandom_range(0, 3)); end
      send(1'($urandom_range(0, 1)), len, 1'b0);
    end
    rnd_en = 1'b0;
    tick(1);
    tx_dst_n = 1'b0;
    mark_next = 1'b1;
    drain();
    chk("t5_err_count", 64'(err_seen), 64'(err_exp));

    // 6: reset while inside the mark region, then a normal frame
    mark_next = 1'b0;
    for (int i = 0; i < 6; i++) begin fw[i] = 32'h6000_0000 + 32'(i); fr[i] = 2'd2; end
    send(1'b1, 5, 1'b0);
    tick(3);
    chk("t6_vld_before_reset", 64'(mvld4), 64'd1);
    fw[0] = 32'h6666_6666; fr[0] = 2'd0;
    q_tx.push_back({1'b1, fw[0], fr[0], 1'b0, 1'b1, 1'b0, 1'b1});
    send(1'b1, 1, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_vld_after_reset", 64'(mvld4), 64'd0);
    chk("t6_mark_after_reset", mark4, 64'd0);
    chk("t6_tx_src_after_reset", 64'(tx4.SRC_RDY_N), 64'd1);
    chk("t6_tx_queue_before_discard", 64'(q_tx.size()), 64'd0);
    void'(q_mk4.pop_front());
    mark_next = 1'b1;
    for (int i = 0; i < 6; i++) begin fw[i] = 32'h7000_0000 + 32'(i); fr[i] = 2'd1; end
    c0 = tx_pop;
    send(1'b1, 6, 1'b0);
    drain();
    chk("t6_tx_words", 64'(tx_pop - c0), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
